selsplit_sched: RTL and testbench
=================================

Name: selsplit_sched

Overview:
Clocked scheduler that sequences a 2-way conditional split stage with drive/free handshakes and a separate data path. It accepts tokens from a synchronous valid/ready source, resolves the destination mask, and gates issue on per-output downstream credits. It then presents data and valid0/valid1, pulses drive, and waits for the split's free acknowledge before accepting the next token. It sits at the boundary between the clocked FPGA control plane and the self-timed split fabric.

Parameters:
DATA_WIDTH, 32, token payload width.
CREDIT_MAX, 4, per-output credit depth (≥1); counter width = clog2(CREDIT_MAX+1).
DRIVE_PULSE, 2, o_drive high time in clk cycles (≥1).
SYNC_STAGES, 2, flops in the i_free synchronizer (≥2).
TIMEOUT_CYCLES, 255, WAIT watchdog limit (used only with the optional feature).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
s_valid  input  1  upstream token valid.
s_ready  output  1  scheduler can accept a token.
s_data  input  DATA_WIDTH  token payload.
s_dest  input  2  bit0 selects out0, bit1 selects out1; 2'b00 selects auto load-balance.
credit_ret0  input  1  one-cycle pulse; downstream 0 returns one credit.
credit_ret1  input  1  one-cycle pulse; downstream 1 returns one credit.
o_drive  output  1  drive pulse to split.
o_valid0  output  1  route-to-out0 level to split.
o_valid1  output  1  route-to-out1 level to split.
o_data  output  DATA_WIDTH  registered payload to split.
i_free  input  1  free acknowledge from split; asynchronous to clk.
o_credit0  output  clog2(CREDIT_MAX+1)  current credit count, out0.
o_credit1  output  clog2(CREDIT_MAX+1)  current credit count, out1.
o_busy  output  1  high in every state except IDLE.
o_err  output  1  sticky protocol error; cleared only by reset.
o_timeout  output  1  sticky watchdog flag (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. s_ready, o_drive, o_valid0/1, o_busy, o_err, o_timeout = 0. o_data=0. Both credits = CREDIT_MAX. rr_ptr=0. Synchronizer flops cleared. A reset during DRIVE drops o_drive immediately; credits already consumed are restored to CREDIT_MAX.
- s_ready = (state==IDLE) while out of reset. Handshake completes on s_valid & s_ready. s_data is captured into o_data and s_dest into dest_r; next state is ARB.
- ARB: mask = dest_r when nonzero. When dest_r=00:
  - only one output has credit → that output;
  - both have credit → the output with the larger count; on a tie, rr_ptr selects the output and rr_ptr toggles;
  - neither has credit → re-evaluate next cycle.
- ARB holds until every masked output has credit>0. On the leaving cycle it decrements the masked credits, registers o_valid0/1 = mask, and goes to SETUP.
- SETUP: 1 cycle; data/valids stable, o_drive=0. Guarantees data setup into the self-timed stage.
- DRIVE: o_drive=1 for exactly DRIVE_PULSE cycles, then WAIT.
- WAIT: o_drive=0; o_valid0/1 and o_data held. A rising edge of the synchronized i_free returns to IDLE and clears o_valid0/1 in the same transition.
- Latency: handshake at cycle N → ARB at N+1 (credit available) → SETUP at N+2 → o_drive at N+3..N+2+DRIVE_PULSE. i_free rising is seen SYNC_STAGES+1 cycles later; s_ready rises the following cycle.
- Credits: a return increments the count. A return on the same cycle as the ARB decrement leaves the count unchanged. A return at CREDIT_MAX saturates the count and sets o_err.
- A synchronized i_free rising edge outside WAIT is ignored and sets o_err.
- s_dest is sampled only at handshake; later changes have no effect.
- o_busy=1 in ARB, SETUP, DRIVE, WAIT.

Optional Feature:
Macro SELSPLIT_SCHED_TIMEOUT_EN.
- Defined: a counter runs in WAIT and resets on WAIT entry. When it reaches TIMEOUT_CYCLES with no free edge:
  - o_timeout is set (sticky);
  - o_valid0/1 are cleared and the state returns to IDLE;
  - consumed credits are NOT restored;
  - a later stray free edge sets o_err.
- Not defined: WAIT holds indefinitely, no counter is synthesized, and o_timeout is tied 0.

Test Plan:
- Unicast: reset, s_dest=01, s_data=0xA5A5A5A5 → o_valid0=1, o_valid1=0, o_data=0xA5A5A5A5, o_drive high 2 cycles starting handshake+3, o_credit0 4→3; i_free pulse → s_ready=1 after SYNC_STAGES+2 cycles.
- Broadcast: s_dest=11 → both valids=1, both credits decrement. Credit starvation: 4 tokens to out0 with no credit_ret → 5th token stalls in ARB with o_busy=1 and o_drive=0; one credit_ret0 pulse → issue 3 cycles later.
- Auto balance: s_dest=00 with credits 4/4 → out0 (rr_ptr=0), then out1 on tie 3/3... after 4 tokens and no returns, credits equal 2/2.
- Simultaneous return/decrement: credit_ret0 pulse on the ARB exit cycle → o_credit0 unchanged. credit_ret1 at CREDIT_MAX → o_err=1, count stays 4.
- Stray free in IDLE → o_err=1, no state change. Assert rst mid-DRIVE → o_drive=0 immediately, credits=4/4, s_ready=1 after release.
- With SELSPLIT_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold i_free → o_timeout=1 at WAIT+16, valids=0, IDLE, consumed credit not returned.

Source files
------------

// File: rtl/selsplit_sched_if.sv
// selsplit_sched_if: token source, split drive/free, credit return and status signals of the scheduler.
interface selsplit_sched_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CW         = 3
);
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic [1:0]            s_dest;
  logic                  credit_ret0;
  logic                  credit_ret1;
  logic                  o_drive;
  logic                  o_valid0;
  logic                  o_valid1;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  i_free;
  logic [CW-1:0]         o_credit0;
  logic [CW-1:0]         o_credit1;
  logic                  o_busy;
  logic                  o_err;
  logic                  o_timeout;
  modport master (
    input  s_valid, s_data, s_dest, credit_ret0, credit_ret1, i_free,
    output s_ready, o_drive, o_valid0, o_valid1, o_data, o_credit0, o_credit1, o_busy, o_err, o_timeout
  );
  modport slave (
    output s_valid, s_data, s_dest, credit_ret0, credit_ret1, i_free,
    input  s_ready, o_drive, o_valid0, o_valid1, o_data, o_credit0, o_credit1, o_busy, o_err, o_timeout
  );
endinterface

// File: rtl/selsplit_sched.sv
// selsplit_sched: credit-gated scheduler driving a 2-way self-timed split via drive/free handshake.
// Optional WAIT watchdog enabled by SELSPLIT_SCHED_TIMEOUT_EN.
module selsplit_sched #(
  parameter int DATA_WIDTH     = 32,
  parameter int CREDIT_MAX     = 4,
  parameter int DRIVE_PULSE    = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic clk,
  input logic rst,
  selsplit_sched_if.master bus
);
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam int DCW = DRIVE_PULSE > 1 ? $clog2(DRIVE_PULSE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_MAX);
  if (CREDIT_MAX < 1 || DRIVE_PULSE < 1 || SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("selsplit_sched: illegal parameter set");
  end
  typedef enum logic [2:0] {IDLE, ARB, SETUP, DRIVE, WAIT} state_t;
  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            dest_q, dest_d, valid_q, valid_d;
  logic [DCW-1:0]        dcnt_q, dcnt_d;
  logic [CW-1:0]         c0_q, c0_d, c1_q, c1_d;
  logic                  drive_q, drive_d, rr_q, rr_d, err_q, err_d;
  logic [SYNC_STAGES:0]  sync_q;
  logic                  rise_q;
  logic                  has0, has1, tie, go, ovf0, ovf1;
  logic [1:0]            auto_mask, mask;
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          to_q, to_d;
`endif
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] c, input logic ret, input logic dec);
    return (ret && !dec && c != CMAX) ? c + CW'(1) : (dec && !ret) ? c - CW'(1) : c;
  endfunction
  assign has0 = |c0_q;
  assign has1 = |c1_q;
  assign tie = has0 && has1 && c0_q == c1_q && dest_q == 2'b00;
  assign auto_mask = (has0 && has1) ? ((c0_q > c1_q) ? 2'b01 : (c1_q > c0_q) ? 2'b10 : (rr_q ? 2'b10 : 2'b01))
                                    : {has1, has0};
  assign mask = |dest_q ? dest_q : auto_mask;
  assign go = state_q == ARB && |mask && (!mask[0] || has0) && (!mask[1] || has1);
  // A return while the same counter is being consumed nets out and cannot overflow.
  assign ovf0 = bus.credit_ret0 && !(go && mask[0]) && c0_q == CMAX;
  assign ovf1 = bus.credit_ret1 && !(go && mask[1]) && c1_q == CMAX;
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dest_d  = dest_q;
    valid_d = valid_q;
    dcnt_d  = dcnt_q;
    rr_d    = rr_q ^ (go && tie);
    c0_d    = credit_next(c0_q, bus.credit_ret0, go && mask[0]);
    c1_d    = credit_next(c1_q, bus.credit_ret1, go && mask[1]);
    err_d   = err_q || (rise_q && state_q != WAIT) || ovf0 || ovf1;
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
    tcnt_d  = tcnt_q;
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: if (bus.s_valid) begin
        data_d  = bus.s_data;
        dest_d  = bus.s_dest;
        state_d = ARB;
      end
      ARB: if (go) begin
        valid_d = mask;
        state_d = SETUP;
      end
      SETUP: begin
        dcnt_d  = '0;
        state_d = DRIVE;
      end
      DRIVE: begin
        dcnt_d  = dcnt_q + DCW'(1);
        state_d = (dcnt_q == DCW'(DRIVE_PULSE - 1)) ? WAIT : DRIVE;
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      WAIT: if (rise_q) begin
        valid_d = 2'b00;
        state_d = IDLE;
      end
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
      else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        valid_d = 2'b00;
        to_d    = 1'b1;
        state_d = IDLE;
      end else tcnt_d = tcnt_q + TW'(1);
`endif
      default: state_d = IDLE;
    endcase
    drive_d = state_d == DRIVE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      dest_q  <= '0;
      valid_q <= '0;
      dcnt_q  <= '0;
      c0_q    <= CMAX;
      c1_q    <= CMAX;
      drive_q <= 1'b0;
      rr_q    <= 1'b0;
      err_q   <= 1'b0;
      sync_q  <= '0;
      rise_q  <= 1'b0;
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
      tcnt_q  <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      dest_q  <= dest_d;
      valid_q <= valid_d;
      dcnt_q  <= dcnt_d;
      c0_q    <= c0_d;
      c1_q    <= c1_d;
      drive_q <= drive_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      sync_q  <= {sync_q[SYNC_STAGES-1:0], bus.i_free};
      rise_q  <= sync_q[SYNC_STAGES-1] && !sync_q[SYNC_STAGES];
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
`endif
    end
  assign bus.s_ready   = rst && state_q == IDLE;
  assign bus.o_busy    = state_q != IDLE;
  assign bus.o_drive   = drive_q;
  assign bus.o_valid0  = valid_q[0];
  assign bus.o_valid1  = valid_q[1];
  assign bus.o_data    = data_q;
  assign bus.o_credit0 = c0_q;
  assign bus.o_credit1 = c1_q;
  assign bus.o_err     = err_q;
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
  assign bus.o_timeout = to_q;
`else
  assign bus.o_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_selsplit_sched.sv
// tb_selsplit_sched: directed stimulus with a token-lifecycle reference model checked every cycle.
module tb_selsplit_sched;
  localparam int DW = 32, CM = 4, DP = 2, SS = 2, TO = 16, CW = $clog2(CM + 1);
  localparam int P_IDLE = 0, P_ARB = 1, P_SETUP = 2, P_DRIVE = 3, P_WAIT = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  selsplit_sched_if #(.DATA_WIDTH(DW), .CW(CW)) bus ();
  selsplit_sched #(.DATA_WIDTH(DW), .CREDIT_MAX(CM), .DRIVE_PULSE(DP), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO))
    dut (.clk(clk), .rst(rst), .bus(bus));
  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic bound_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event never arrived within bound (cycle %0d)", name, cyc);
  endtask
  // Reference model: token lifecycle, credit bookkeeping and a delayed view of i_free.
  int mc0 = CM, mc1 = CM, mph = P_IDLE, mprev, mdcnt = 0, mwait = 0, r0, r1, d0, d1;
  logic [DW-1:0] mdata = '0;
  logic [1:0] mdest = 2'b00, mval = 2'b00, m;
  bit mrr = 0, merr = 0, mto = 0, seen;
  logic [SS+1:0] fh = '0;
  always @(posedge clk or negedge rst)
    if (!rst) begin
      mc0 = CM; mc1 = CM; mph = P_IDLE; mdata = '0; mdest = 2'b00; mval = 2'b00;
      mrr = 0; merr = 0; mto = 0; fh = '0; mdcnt = 0; mwait = 0;
    end else begin
      seen = fh[SS] && !fh[SS+1];
      fh = {fh[SS:0], bus.i_free};
      r0 = int'(bus.credit_ret0); r1 = int'(bus.credit_ret1); d0 = 0; d1 = 0;
      mprev = mph;
      if (mph == P_IDLE) begin
        if (bus.s_valid) begin mdata = bus.s_data; mdest = bus.s_dest; mph = P_ARB; end
      end else if (mph == P_ARB) begin
        if (mdest != 2'b00) m = mdest;
        else if (mc0 > 0 && mc1 > 0) m = (mc0 > mc1) ? 2'b01 : (mc1 > mc0) ? 2'b10 : (mrr ? 2'b10 : 2'b01);
        else m = {mc1 > 0, mc0 > 0};
        if (m != 2'b00 && (!m[0] || mc0 > 0) && (!m[1] || mc1 > 0)) begin
          if (mdest == 2'b00 && mc0 > 0 && mc0 == mc1) mrr = !mrr;
          d0 = int'(m[0]); d1 = int'(m[1]); mval = m; mph = P_SETUP;
        end
      end else if (mph == P_SETUP) begin
        mph = P_DRIVE; mdcnt = 0;
      end else if (mph == P_DRIVE) begin
        mdcnt++;
        if (mdcnt == DP) begin mph = P_WAIT; mwait = 0; end
      end else if (seen) begin
        mph = P_IDLE; mval = 2'b00;
      end
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
      else begin
        mwait++;
        if (mwait == TO) begin mto = 1; mval = 2'b00; mph = P_IDLE; end
      end
`endif
      if (seen && mprev != P_WAIT) merr = 1;
      mc0 = mc0 + r0 - d0;
      mc1 = mc1 + r1 - d1;
      if (mc0 > CM) begin mc0 = CM; merr = 1; end
      if (mc1 > CM) begin mc1 = CM; merr = 1; end
    end
  always @(negedge clk) begin
    chk("s_ready", bus.s_ready, rst && mph == P_IDLE);
    chk("o_busy", bus.o_busy, mph != P_IDLE);
    chk("o_drive", bus.o_drive, mph == P_DRIVE);
    chk("o_valid0", bus.o_valid0, mval[0]);
    chk("o_valid1", bus.o_valid1, mval[1]);
    chk("o_data", bus.o_data, mdata);
    chk("o_credit0", bus.o_credit0, mc0);
    chk("o_credit1", bus.o_credit1, mc1);
    chk("o_err", bus.o_err, merr);
    chk("o_timeout", bus.o_timeout, mto);
  end
  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk); @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
  endtask
  task automatic send(input logic [DW-1:0] d, input logic [1:0] dst, input bit ret_in_arb, output int hs);
    int n = 0;
    @(negedge clk);
    while (!bus.s_ready && n < 100) begin @(negedge clk); n++; end
    if (!bus.s_ready) bound_fail("send_ready");
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_dest = dst; hs = cyc;
    @(negedge clk);
    bus.s_valid = 1'b0; bus.s_dest = ~dst; bus.credit_ret0 = ret_in_arb;
    @(negedge clk);
    bus.credit_ret0 = 1'b0;
  endtask
  task automatic wait_drive(output int first, output int width, output logic [1:0] val, output logic [DW-1:0] dat);
    int n = 0;
    first = -1; width = 0; val = 2'b00; dat = '0;
    while (!bus.o_drive && n < 50) begin @(negedge clk); n++; end
    if (!bus.o_drive) begin bound_fail("drive_start"); return; end
    first = cyc; val = {bus.o_valid1, bus.o_valid0}; dat = bus.o_data;
    while (bus.o_drive && width < 50) begin width++; @(negedge clk); end
  endtask
  task automatic free_pulse(output int lat);
    int n = 0, c;
    bus.i_free = 1'b1; c = cyc;
    @(negedge clk); @(negedge clk);
    bus.i_free = 1'b0;
    while (!bus.s_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.s_ready) bound_fail("free_release");
    lat = cyc - c;
  endtask
  task automatic pulse_ret(input bit which);
    @(negedge clk);
    if (which) bus.credit_ret1 = 1'b1; else bus.credit_ret0 = 1'b1;
    @(negedge clk);
    bus.credit_ret0 = 1'b0; bus.credit_ret1 = 1'b0;
  endtask
  task automatic xfer(input logic [DW-1:0] d, input logic [1:0] dst, input bit ret_in_arb,
                      output int hs, output int first, output int width, output logic [1:0] val,
                      output logic [DW-1:0] dat, output int lat);
    send(d, dst, ret_in_arb, hs);
    wait_drive(first, width, val, dat);
    free_pulse(lat);
  endtask
  int hs, first, width, lat, r, n;
  logic [1:0] val;
  logic [DW-1:0] dat;
  logic [1:0] auto_exp [4] = '{2'b01, 2'b10, 2'b10, 2'b01};
  initial begin
    bus.s_valid = 0; bus.s_data = '0; bus.s_dest = 2'b00;
    bus.credit_ret0 = 0; bus.credit_ret1 = 0; bus.i_free = 0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.s_ready, 1'b0);
    chk("rst_credit0", bus.o_credit0, 4);
    chk("rst_credit1", bus.o_credit1, 4);
    #2 rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus.s_ready, 1'b1);
    xfer(32'hA5A5A5A5, 2'b01, 0, hs, first, width, val, dat, lat);
    chk("uni_drive_lat", first - hs, 3);
    chk("uni_drive_width", width, 2);
    chk("uni_valids", val, 2'b01);
    chk("uni_data", dat, 32'hA5A5A5A5);
    chk("uni_credit0", bus.o_credit0, 3);
    chk("uni_free_lat", lat, SS + 2);
    xfer(32'h12345678, 2'b11, 0, hs, first, width, val, dat, lat);
    chk("bc_valids", val, 2'b11);
    chk("bc_credits", {bus.o_credit1, bus.o_credit0}, {3'd3, 3'd2});
    do_reset();
    for (int i = 0; i < 4; i++) xfer(32'h100 + i, 2'b01, 0, hs, first, width, val, dat, lat);
    chk("starve_credit0", bus.o_credit0, 0);
    send(32'hDEADBEEF, 2'b01, 0, hs);
    repeat (5) @(negedge clk);
    chk("starve_busy", bus.o_busy, 1'b1);
    chk("starve_nodrive", bus.o_drive, 1'b0);
    @(negedge clk); bus.credit_ret0 = 1'b1; r = cyc;
    @(negedge clk); bus.credit_ret0 = 1'b0;
    wait_drive(first, width, val, dat);
    chk("starve_issue_lat", first - r, 3);
    chk("starve_data", dat, 32'hDEADBEEF);
    free_pulse(lat);
    pulse_ret(0); pulse_ret(0);
    chk("ret_credit0", bus.o_credit0, 2);
    xfer(32'h55AA55AA, 2'b01, 1, hs, first, width, val, dat, lat);
    chk("simul_credit0", bus.o_credit0, 2);
    chk("pre_ovf_err", bus.o_err, 1'b0);
    pulse_ret(1);
    chk("ovf_err", bus.o_err, 1'b1);
    chk("ovf_credit1", bus.o_credit1, 4);
    do_reset();
    chk("reset_clears_err", bus.o_err, 1'b0);
    for (int i = 0; i < 4; i++) begin
      xfer(32'h200 + i, 2'b00, 0, hs, first, width, val, dat, lat);
      chk($sformatf("auto_mask%0d", i), val, auto_exp[i]);
    end
    chk("auto_credits", {bus.o_credit1, bus.o_credit0}, {3'd2, 3'd2});
    @(negedge clk); bus.i_free = 1'b1;
    @(negedge clk); bus.i_free = 1'b0;
    repeat (6) @(negedge clk);
    chk("stray_err", bus.o_err, 1'b1);
    chk("stray_ready", bus.s_ready, 1'b1);
    send(32'hCAFEF00D, 2'b10, 0, hs);
    @(negedge clk);
    chk("mid_drive_on", bus.o_drive, 1'b1);
    #2 rst = 1'b0;
    #1 chk("rst_drops_drive", bus.o_drive, 1'b0);
    chk("rst_restores_credits", {bus.o_credit1, bus.o_credit0}, {3'd4, 3'd4});
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", bus.s_ready, 1'b1);
`ifdef SELSPLIT_SCHED_TIMEOUT_EN
    send(32'h0BADF00D, 2'b01, 0, hs);
    wait_drive(first, width, val, dat);
    n = 0;
    while (!bus.o_timeout && n < 60) begin @(negedge clk); n++; end
    if (!bus.o_timeout) bound_fail("timeout_flag");
    chk("timeout_lat", cyc - first, DP + TO);
    chk("timeout_valids", {bus.o_valid1, bus.o_valid0}, 2'b00);
    chk("timeout_ready", bus.s_ready, 1'b1);
    chk("timeout_credit0", bus.o_credit0, 3);
    @(negedge clk); bus.i_free = 1'b1;
    @(negedge clk); bus.i_free = 1'b0;
    repeat (6) @(negedge clk);
    chk("timeout_late_free_err", bus.o_err, 1'b1);
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end
endmodule
